// File: rtl/plic_arb_pkg.sv
// rtl/plic_arb_pkg.sv - shared types and the rotating-priority pick function for the PLIC Wishbone arbiter
package plic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } arb_state_t;

    localparam int MAX_MASTERS = 32;
    localparam int MAX_IDX_W   = 5;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 valid;
    } pick_t;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scan last+1, last+2, ... modulo n; the first set request wins.
    function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                      input logic [MAX_IDX_W-1:0]   last,
                                      input int                     n);
        pick_t res;
        int    k;
        res = '0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            if (i <= n && !res.valid) begin
                k = int'(last) + i;
                if (k >= n) begin
                    k = k - n;
                end
                if (req[k[MAX_IDX_W-1:0]]) begin
                    res.idx   = k[MAX_IDX_W-1:0];
                    res.valid = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/plic_rr_picker.sv
// rtl/plic_rr_picker.sv - combinational rotating-priority picker over N request lines
module plic_rr_picker #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] idx,
    output logic          valid
);
    import plic_arb_pkg::*;

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_IDX_W-1:0]   last_ext;
    pick_t                  res;

    always_comb begin
        req_ext            = '0;
        req_ext[N-1:0]     = req;
        last_ext           = '0;
        last_ext[GW-1:0]   = last;
        res                = rr_pick(req_ext, last_ext, N);
        idx                = res.idx[GW-1:0];
        valid              = res.valid && (int'(res.idx) < N);
    end

endmodule

// File: rtl/plic_wb_arbiter.sv
// rtl/plic_wb_arbiter.sv - round-robin Wishbone arbiter in front of the PLIC slave; PLIC_ARB_TIMEOUT_EN adds an ack timeout
module plic_wb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int PADDR_SIZE     = 30,
    parameter int PDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*PADDR_SIZE-1:0] m_adr,
    input  logic [NUM_MASTERS*PDATA_SIZE-1:0] m_dat_i,
    output logic [PDATA_SIZE-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [PADDR_SIZE-1:0]             s_adr,
    output logic [PDATA_SIZE-1:0]             s_dat_o,
    input  logic [PDATA_SIZE-1:0]             s_dat_i,
    input  logic                              s_ack
);
    import plic_arb_pkg::*;

    localparam int GRANT_W = grant_w(NUM_MASTERS);

    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_q, last_d;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_valid;

`ifdef PLIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_pulse_q, err_pulse_d;
`endif

    plic_rr_picker #(
        .N  (NUM_MASTERS),
        .GW (GRANT_W)
    ) u_picker (
        .req   (m_cyc & m_stb),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef PLIC_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
`ifdef PLIC_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // Releasing cyc ends the grant, acked or not.
                if (!m_cyc[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
`ifdef PLIC_ARB_TIMEOUT_EN
                else if (s_ack) begin
                    cnt_d = '0;
                end else if (m_stb[grant_q]) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d     = ERR;
                        err_pulse_d = 1'b1;
                    end
                end
`endif
            end
`ifdef PLIC_ARB_TIMEOUT_EN
            ERR: begin
                if (!m_cyc[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        m_ack   = '0;
        m_err   = '0;
        if (state_q == BUSY) begin
            s_cyc          = m_cyc[grant_q];
            s_stb          = m_stb[grant_q];
            s_we           = m_we[grant_q];
            s_adr          = m_adr[int'(grant_q)*PADDR_SIZE +: PADDR_SIZE];
            s_dat_o        = m_dat_i[int'(grant_q)*PDATA_SIZE +: PDATA_SIZE];
            m_ack[grant_q] = s_ack;
        end
`ifdef PLIC_ARB_TIMEOUT_EN
        if (state_q == ERR && err_pulse_q) begin
            m_err[grant_q] = 1'b1;
        end
`endif
    end

    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GRANT_W'(NUM_MASTERS - 1);
`ifdef PLIC_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef PLIC_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_pulse_q <= err_pulse_d;
`endif
        end
    end

endmodule

// File: tb/tb_plic_wb_arbiter.sv
// tb/tb_plic_wb_arbiter.sv - directed self-checking bench for plic_wb_arbiter
module tb_plic_wb_arbiter;
    localparam int NM = 2;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [AW-1:0] ADR0 = 30'h00100;
    localparam logic [AW-1:0] ADR1 = 30'h80000;
    localparam logic [DW-1:0] DAT0 = 32'haaaa0000;
    localparam logic [DW-1:0] DAT1 = 32'hbbbb0001;

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack, m_err;
    logic             s_cyc, s_stb, s_we;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat_o, s_dat_i;
    logic             s_ack;

    int checks = 0;
    int errors = 0;
    int exp_g [4] = '{0, 1, 0, 1};

    always #5 clk = ~clk;

    plic_wb_arbiter #(
        .NUM_MASTERS    (NM),
        .PADDR_SIZE     (AW),
        .PDATA_SIZE     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        m_cyc   = 2'b11;
        m_stb   = 2'b11;
        m_we    = 2'b01;
        m_adr   = {ADR1, ADR0};
        m_dat_i = {DAT1, DAT0};
        s_dat_i = '0;
        s_ack   = 1'b1;
        repeat (3) step();
        settle();
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_s_adr", s_adr, 0);

        reset = 1'b1;
        s_ack = 1'b0;
        settle();
        chk("idle_s_cyc", s_cyc, 0);
        step(); settle();
        chk("g0_s_cyc", s_cyc, 1);
        chk("g0_s_adr", s_adr, ADR0);
        chk("g0_s_we", s_we, 1);
        chk("g0_s_dat_o", s_dat_o, DAT0);
        s_ack = 1'b1;
        settle();
        chk("g0_ack", m_ack, 2'b01);
        step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
        settle();
        step(); settle();
        chk("rel_idle", s_cyc, 0);

        step(); settle();
        chk("rd_s_cyc", s_cyc, 1);
        chk("rd_s_adr", s_adr, 30'h80000);
        chk("rd_s_we", s_we, 0);
        s_ack = 1'b1; s_dat_i = 32'h00000005;
        settle();
        chk("rd_ack", m_ack, 2'b10);
        chk("rd_dat", m_dat_o, 32'h5);
        step();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0; s_dat_i = '0;
        settle();
        step(); settle();
        chk("rd_idle", s_cyc, 0);

        m_cyc = 2'b11; m_stb = 2'b11;
        settle();
        for (int t = 0; t < 4; t++) begin
            step(); settle();
            chk("ct_s_adr", s_adr, (exp_g[t] == 1) ? ADR1 : ADR0);
            s_ack = 1'b1;
            settle();
            chk("ct_ack", m_ack, (exp_g[t] == 1) ? 2'b10 : 2'b01);
            step();
            m_cyc[exp_g[t]] = 1'b0; m_stb[exp_g[t]] = 1'b0; s_ack = 1'b0;
            settle();
            step(); settle();
            chk("ct_idle", s_cyc, 0);
            m_cyc[exp_g[t]] = 1'b1; m_stb[exp_g[t]] = 1'b1;
            settle();
        end

        step(); settle();
        chk("lk_grant", s_adr, ADR0);
        s_ack = 1'b1;
        settle();
        chk("lk_ack1", m_ack, 2'b01);
        step();
        m_stb[0] = 1'b0; s_ack = 1'b0;
        settle();
        chk("lk_stb0", s_stb, 0);
        chk("lk_hold", s_cyc, 1);
        step();
        m_stb[0] = 1'b1; s_ack = 1'b1;
        settle();
        chk("lk_ack2", m_ack, 2'b01);
        chk("lk_adr", s_adr, ADR0);
        step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
        settle();
        step(); settle();
        chk("lk_idle", s_cyc, 0);
        step(); settle();
        chk("lk_next_adr", s_adr, ADR1);
        chk("lk_next_cyc", s_cyc, 1);

        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        settle();
        step(); settle();
        step(); settle();
        chk("ab_grant_adr", s_adr, ADR0);
        chk("ab_grant_cyc", s_cyc, 1);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        settle();
        step();
        s_ack = 1'b1;
        settle();
        chk("ab_late_ack", m_ack, 0);
        chk("ab_idle", s_cyc, 0);
        s_ack = 1'b0;

        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        settle();
        step(); settle();
        chk("mr_busy", s_cyc, 1);
        reset = 1'b0; s_ack = 1'b1;
        step(); settle();
        chk("mr_s_cyc", s_cyc, 0);
        chk("mr_m_ack", m_ack, 0);
        reset = 1'b1; s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        settle();
        step(); settle();

        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        settle();
        step(); settle();
`ifdef PLIC_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk("to_busy", s_cyc, 1);
            chk("to_noerr", m_err, 0);
            step(); settle();
        end
        chk("to_err", m_err, 2'b01);
        chk("to_s_cyc", s_cyc, 0);
        s_ack = 1'b1;
        settle();
        chk("to_ack_ign", m_ack, 0);
        s_ack = 1'b0;
        step(); settle();
        chk("to_err_once", m_err, 0);
        chk("to_s_cyc2", s_cyc, 0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        settle();
        step(); settle();
        chk("to_idle", s_cyc, 0);
        step(); settle();
        chk("to_next_adr", s_adr, ADR1);
        chk("to_next_cyc", s_cyc, 1);
`else
        repeat (20) step();
        settle();
        chk("nt_hold_cyc", s_cyc, 1);
        chk("nt_hold_adr", s_adr, ADR0);
        chk("nt_no_err", m_err, 0);
`endif
        m_cyc = '0; m_stb = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
